// File: rtl/cluster_unpacker.sv
// Expands eight {cnt, adr} cluster words into 24 VFAT S-bit maps, one cluster per
// clock, and presents the decoded frame under a valid/ready handshake.
module cluster_unpacker #(
  parameter int MXSBITS    = 64,
  parameter int MXKEYS     = 192,
  parameter int MXCLUSTERS = 8,
  parameter int MXCLSTBITS = 14
) (
  input  logic                  clock4x,
  input  logic                  global_reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MXCLSTBITS-1:0] cluster0,
  input  logic [MXCLSTBITS-1:0] cluster1,
  input  logic [MXCLSTBITS-1:0] cluster2,
  input  logic [MXCLSTBITS-1:0] cluster3,
  input  logic [MXCLSTBITS-1:0] cluster4,
  input  logic [MXCLSTBITS-1:0] cluster5,
  input  logic [MXCLSTBITS-1:0] cluster6,
  input  logic [MXCLSTBITS-1:0] cluster7,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MXSBITS-1:0]    vfat0,
  output logic [MXSBITS-1:0]    vfat1,
  output logic [MXSBITS-1:0]    vfat2,
  output logic [MXSBITS-1:0]    vfat3,
  output logic [MXSBITS-1:0]    vfat4,
  output logic [MXSBITS-1:0]    vfat5,
  output logic [MXSBITS-1:0]    vfat6,
  output logic [MXSBITS-1:0]    vfat7,
  output logic [MXSBITS-1:0]    vfat8,
  output logic [MXSBITS-1:0]    vfat9,
  output logic [MXSBITS-1:0]    vfat10,
  output logic [MXSBITS-1:0]    vfat11,
  output logic [MXSBITS-1:0]    vfat12,
  output logic [MXSBITS-1:0]    vfat13,
  output logic [MXSBITS-1:0]    vfat14,
  output logic [MXSBITS-1:0]    vfat15,
  output logic [MXSBITS-1:0]    vfat16,
  output logic [MXSBITS-1:0]    vfat17,
  output logic [MXSBITS-1:0]    vfat18,
  output logic [MXSBITS-1:0]    vfat19,
  output logic [MXSBITS-1:0]    vfat20,
  output logic [MXSBITS-1:0]    vfat21,
  output logic [MXSBITS-1:0]    vfat22,
  output logic [MXSBITS-1:0]    vfat23,
  output logic [3:0]            n_valid,
  output logic                  clipped
);

  localparam int NVFAT = 24;
  localparam int MAPW  = NVFAT * MXSBITS;

  typedef enum logic [1:0] {IDLE, DECODE, EMIT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              idx;
  logic [MXCLSTBITS-1:0]   clst [MXCLUSTERS];
  logic [MAPW-1:0]         map_w, map_o, map_nxt;
  logic [3:0]              nv_w, nv_nxt;
  logic                    clip_w, clip_nxt, accept;
  logic [MXCLSTBITS-1:0]   cur;

  function automatic logic cluster_live(input logic [MXCLSTBITS-1:0] c);
    return int'(c[10:0]) < MAPW;
  endfunction

  function automatic logic cluster_clips(input logic [MXCLSTBITS-1:0] c);
    return cluster_live(c) && ((int'(c[10:0]) % MXKEYS) + int'(c[13:11]) > MXKEYS - 1);
  endfunction

  // Global pad index adr+j lands on the right vfat/bit directly; the key test keeps
  // the run inside its own partition row.
  function automatic logic [MAPW-1:0] cluster_mask(input logic [MXCLSTBITS-1:0] c);
    logic [MAPW-1:0] m;
    logic [10:0]     bi;
    int              adr, cnt, k;
    m   = '0;
    adr = int'(c[10:0]);
    cnt = int'(c[13:11]);
    k   = adr % MXKEYS;
    if (adr < MAPW) begin
      for (int j = 0; j < 8; j++) begin
        if (j <= cnt && k + j < MXKEYS) begin
          bi    = 11'(adr + j);
          m[bi] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  assign accept   = (state == IDLE) && in_ready && in_valid;
  assign cur      = clst[idx];
  assign map_nxt  = map_w | cluster_mask(cur);
  assign nv_nxt   = nv_w + {3'b000, cluster_live(cur)};
  assign clip_nxt = clip_w | cluster_clips(cur);

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DECODE;
      DECODE:  if (idx == 3'd7) state_nxt = EMIT;
      EMIT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working bitmap accumulates during DECODE; the output copy only changes on entry to EMIT.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      idx       <= '0;
      map_w     <= '0;
      nv_w      <= '0;
      clip_w    <= 1'b0;
      map_o     <= '0;
      n_valid   <= '0;
      clipped   <= 1'b0;
      for (int i = 0; i < MXCLUSTERS; i++) clst[i] <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == EMIT);
      case (state)
        IDLE: begin
          if (accept) begin
            clst[0] <= cluster0;
            clst[1] <= cluster1;
            clst[2] <= cluster2;
            clst[3] <= cluster3;
            clst[4] <= cluster4;
            clst[5] <= cluster5;
            clst[6] <= cluster6;
            clst[7] <= cluster7;
            map_w   <= '0;
            nv_w    <= '0;
            clip_w  <= 1'b0;
            idx     <= '0;
          end
        end
        DECODE: begin
          map_w  <= map_nxt;
          nv_w   <= nv_nxt;
          clip_w <= clip_nxt;
          idx    <= idx + 3'd1;
          if (idx == 3'd7) begin
            map_o   <= map_nxt;
            n_valid <= nv_nxt;
            clipped <= clip_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign vfat0  = map_o[ 0*MXSBITS +: MXSBITS];
  assign vfat1  = map_o[ 1*MXSBITS +: MXSBITS];
  assign vfat2  = map_o[ 2*MXSBITS +: MXSBITS];
  assign vfat3  = map_o[ 3*MXSBITS +: MXSBITS];
  assign vfat4  = map_o[ 4*MXSBITS +: MXSBITS];
  assign vfat5  = map_o[ 5*MXSBITS +: MXSBITS];
  assign vfat6  = map_o[ 6*MXSBITS +: MXSBITS];
  assign vfat7  = map_o[ 7*MXSBITS +: MXSBITS];
  assign vfat8  = map_o[ 8*MXSBITS +: MXSBITS];
  assign vfat9  = map_o[ 9*MXSBITS +: MXSBITS];
  assign vfat10 = map_o[10*MXSBITS +: MXSBITS];
  assign vfat11 = map_o[11*MXSBITS +: MXSBITS];
  assign vfat12 = map_o[12*MXSBITS +: MXSBITS];
  assign vfat13 = map_o[13*MXSBITS +: MXSBITS];
  assign vfat14 = map_o[14*MXSBITS +: MXSBITS];
  assign vfat15 = map_o[15*MXSBITS +: MXSBITS];
  assign vfat16 = map_o[16*MXSBITS +: MXSBITS];
  assign vfat17 = map_o[17*MXSBITS +: MXSBITS];
  assign vfat18 = map_o[18*MXSBITS +: MXSBITS];
  assign vfat19 = map_o[19*MXSBITS +: MXSBITS];
  assign vfat20 = map_o[20*MXSBITS +: MXSBITS];
  assign vfat21 = map_o[21*MXSBITS +: MXSBITS];
  assign vfat22 = map_o[22*MXSBITS +: MXSBITS];
  assign vfat23 = map_o[23*MXSBITS +: MXSBITS];

endmodule

// File: tb/tb_cluster_unpacker.sv
// Scoreboard bench for cluster_unpacker: a reference model of the pad-to-VFAT mapping
// queues the expected frame at acceptance and each scenario compares it at out_valid.
module tb_cluster_unpacker;

  typedef struct packed {
    logic [23:0][63:0] v;
    logic [3:0]        n;
    logic              clip;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, out_valid, out_ready, clipped;
  logic [13:0]       cl [8];
  logic [23:0][63:0] dv;
  logic [3:0]        n_valid;
  exp_t              sbq[$];
  int                errors = 0;
  int                checks = 0;

  always #5 clk = ~clk;

  cluster_unpacker dut (
    .clock4x(clk), .global_reset_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .vfat0(dv[0]),   .vfat1(dv[1]),   .vfat2(dv[2]),   .vfat3(dv[3]),
    .vfat4(dv[4]),   .vfat5(dv[5]),   .vfat6(dv[6]),   .vfat7(dv[7]),
    .vfat8(dv[8]),   .vfat9(dv[9]),   .vfat10(dv[10]), .vfat11(dv[11]),
    .vfat12(dv[12]), .vfat13(dv[13]), .vfat14(dv[14]), .vfat15(dv[15]),
    .vfat16(dv[16]), .vfat17(dv[17]), .vfat18(dv[18]), .vfat19(dv[19]),
    .vfat20(dv[20]), .vfat21(dv[21]), .vfat22(dv[22]), .vfat23(dv[23]),
    .n_valid(n_valid), .clipped(clipped)
  );

  // Reference: row/key split, then vfat = 3*row + key/64, bit = key%64.
  function automatic exp_t model();
    exp_t e;
    int adr, cnt, r, k, kk;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      adr = int'(cl[i][10:0]);
      cnt = int'(cl[i][13:11]);
      if (adr < 1536) begin
        e.n = e.n + 4'd1;
        r = adr / 192;
        k = adr % 192;
        for (int j = 0; j <= cnt; j++) begin
          kk = k + j;
          if (kk > 191) e.clip = 1'b1;
          else          e.v[3*r + kk/64][kk%64] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic clear_cl();
    for (int i = 0; i < 8; i++) cl[i] = 14'h07FF;
  endtask

  task automatic drive_frame(output int lat);
    in_valid = 1'b1;
    sbq.push_back(model());
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_cl();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got %b exp 0", in_ready); errors++; end
    checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b exp 0", out_valid); errors++; end
    checks++; if (dv !== '0 || n_valid !== 4'd0 || clipped !== 1'b0) begin
      $display("FAIL rst_outputs n_valid=%0d clipped=%b vfat_or=%b exp all 0", n_valid, clipped, |dv); errors++; end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin $display("FAIL rst_release_in_ready got %b exp 1", in_ready); errors++; end
  endtask

  task automatic test_single();
    int lat; exp_t e; logic bad;
    clear_cl();
    cl[0] = {3'd0, 11'd0};
    drive_frame(lat);
    checks++; if (lat !== 8) begin $display("FAIL single_latency got %0d exp 8", lat); errors++; end
    checks++; bad = 1'b0;
    if (sbq.size() == 0) bad = 1'b1;
    else begin
      e = sbq.pop_front();
      for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL single_sb vfat%0d got %h exp %h", i, dv[i], e.v[i]); bad = 1'b1; end
      if (n_valid !== e.n || clipped !== e.clip) begin $display("FAIL single_sb n/clip got %0d/%b exp %0d/%b", n_valid, clipped, e.n, e.clip); bad = 1'b1; end
    end
    if (bad) errors++;
    checks++; if (dv[0] !== 64'h1 || dv[23:1] !== '0) begin $display("FAIL single_vfat0 got %h exp 1 (others 0)", dv[0]); errors++; end
    checks++; if (n_valid !== 4'd1 || clipped !== 1'b0) begin $display("FAIL single_nv got %0d/%b exp 1/0", n_valid, clipped); errors++; end
    checks++; if (in_ready !== 1'b0) begin $display("FAIL single_emit_in_ready got %b exp 0", in_ready); errors++; end
    release_frame();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL single_exit got ov=%b ir=%b exp 0/1", out_valid, in_ready); errors++; end
  endtask

  task automatic test_span();
    int lat; exp_t e; logic bad;
    for (int f = 0; f < 2; f++) begin
      clear_cl();
      cl[1] = {3'd7, 11'd1600};
      if (f == 0) cl[3] = {3'd7, 11'd64};
      else        cl[7] = {3'd7, 11'd1535};
      drive_frame(lat);
      checks++; if (lat !== 8) begin $display("FAIL span%0d_latency got %0d exp 8", f, lat); errors++; end
      checks++; bad = 1'b0;
      if (sbq.size() == 0) bad = 1'b1;
      else begin
        e = sbq.pop_front();
        for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL span%0d_sb vfat%0d got %h exp %h", f, i, dv[i], e.v[i]); bad = 1'b1; end
        if (n_valid !== e.n || clipped !== e.clip) begin $display("FAIL span%0d_sb n/clip got %0d/%b exp %0d/%b", f, n_valid, clipped, e.n, e.clip); bad = 1'b1; end
      end
      if (bad) errors++;
      checks++;
      if (f == 0) begin
        if (dv[1] !== 64'hFF || dv[0] !== '0 || dv[23:2] !== '0 || clipped !== 1'b0) begin
          $display("FAIL span_vfat1 got %h clip %b exp ff/0", dv[1], clipped); errors++; end
      end else begin
        if (dv[23] !== 64'h8000_0000_0000_0000 || dv[22:0] !== '0 || clipped !== 1'b1 || n_valid !== 4'd1) begin
          $display("FAIL span_vfat23 got %h clip %b nv %0d exp 8000000000000000/1/1", dv[23], clipped, n_valid); errors++; end
      end
      release_frame();
    end
  endtask

  task automatic test_edge_clip();
    int lat; exp_t e; logic bad;
    clear_cl();
    cl[5] = {3'd4, 11'd190};
    drive_frame(lat);
    checks++; bad = 1'b0;
    if (sbq.size() == 0) bad = 1'b1;
    else begin
      e = sbq.pop_front();
      for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL edge_sb vfat%0d got %h exp %h", i, dv[i], e.v[i]); bad = 1'b1; end
      if (n_valid !== e.n || clipped !== e.clip) begin $display("FAIL edge_sb n/clip got %0d/%b exp %0d/%b", n_valid, clipped, e.n, e.clip); bad = 1'b1; end
    end
    if (bad) errors++;
    checks++; if (dv[2] !== 64'hC000_0000_0000_0000 || dv[3] !== '0) begin $display("FAIL edge_vfat2 got %h vfat3 %h exp c000000000000000/0", dv[2], dv[3]); errors++; end
    checks++; if (clipped !== 1'b1 || n_valid !== 4'd1) begin $display("FAIL edge_clip got %b/%0d exp 1/1", clipped, n_valid); errors++; end
    release_frame();
  endtask

  task automatic test_overlap();
    int lat; exp_t e; logic bad;
    logic [23:0][63:0] first;
    first = '0;
    for (int f = 0; f < 2; f++) begin
      clear_cl();
      if (f == 0) begin cl[0] = {3'd2, 11'd10}; cl[1] = {3'd3, 11'd11}; cl[2] = {3'd2, 11'd10}; end
      else        begin cl[7] = {3'd2, 11'd10}; cl[4] = {3'd3, 11'd11}; cl[6] = {3'd2, 11'd10}; end
      drive_frame(lat);
      checks++; bad = 1'b0;
      if (sbq.size() == 0) bad = 1'b1;
      else begin
        e = sbq.pop_front();
        for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL overlap%0d_sb vfat%0d got %h exp %h", f, i, dv[i], e.v[i]); bad = 1'b1; end
        if (n_valid !== e.n || clipped !== e.clip) begin $display("FAIL overlap%0d_sb n/clip got %0d/%b exp %0d/%b", f, n_valid, clipped, e.n, e.clip); bad = 1'b1; end
      end
      if (bad) errors++;
      checks++; if (dv[0] !== 64'h7C00 || dv[23:1] !== '0 || n_valid !== 4'd3) begin $display("FAIL overlap%0d_vfat0 got %h nv %0d exp 7c00/3", f, dv[0], n_valid); errors++; end
      if (f == 1) begin
        checks++; if (dv !== first) begin $display("FAIL overlap_order got vfat0 %h exp %h", dv[0], first[0]); errors++; end
      end
      first = dv;
      release_frame();
    end
  endtask

  task automatic test_random();
    int lat; exp_t e; logic bad;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) cl[i] = {3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047))};
      drive_frame(lat);
      checks++; bad = (lat != 8);
      if (sbq.size() == 0) bad = 1'b1;
      else begin
        e = sbq.pop_front();
        for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL random%0d_sb vfat%0d got %h exp %h", f, i, dv[i], e.v[i]); bad = 1'b1; end
        if (n_valid !== e.n || clipped !== e.clip) begin $display("FAIL random%0d_sb n/clip got %0d/%b exp %0d/%b", f, n_valid, clipped, e.n, e.clip); bad = 1'b1; end
      end
      if (bad) begin $display("FAIL random%0d latency %0d exp 8", f, lat); errors++; end
      release_frame();
    end
  endtask

  task automatic test_backpressure();
    int lat; exp_t e; logic bad;
    clear_cl();
    cl[2] = {3'd3, 11'd700};
    drive_frame(lat);
    checks++; bad = (lat != 8);
    e = '0;
    if (sbq.size() == 0) bad = 1'b1;
    else begin
      e = sbq.pop_front();
      if (dv !== e.v || n_valid !== e.n || clipped !== e.clip) bad = 1'b1;
    end
    if (bad) begin $display("FAIL bp_frame lat %0d nv %0d/%0d", lat, n_valid, e.n); errors++; end
    clear_cl();
    cl[0] = {3'd1, 11'd1000};
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || dv !== e.v || n_valid !== e.n || clipped !== e.clip) begin
        $display("FAIL bp_hold cycle %0d ir=%b ov=%b nv=%0d exp ir=0 ov=1 nv=%0d", c, in_ready, out_valid, n_valid, e.n); errors++; end
    end
    in_valid = 1'b0;
    release_frame();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin $display("FAIL bp_exit ov=%b ir=%b exp 0/1", out_valid, in_ready); errors++; end
    drive_frame(lat);
    checks++; bad = (lat != 8);
    if (sbq.size() == 0) bad = 1'b1;
    else begin
      e = sbq.pop_front();
      for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL bp_next vfat%0d got %h exp %h", i, dv[i], e.v[i]); bad = 1'b1; end
      if (n_valid !== e.n || clipped !== e.clip) bad = 1'b1;
    end
    if (bad) begin $display("FAIL bp_next lat %0d nv %0d exp 8/%0d", lat, n_valid, e.n); errors++; end
    release_frame();
  endtask

  task automatic test_back_to_back();
    int acc_at [8];
    int nacc, nout;
    logic acc, bad;
    exp_t e;
    nacc = 0; nout = 0;
    clear_cl();
    cl[0] = {3'd1, 11'd50};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        nout++;
        checks++; bad = 1'b0;
        if (sbq.size() == 0) bad = 1'b1;
        else begin
          e = sbq.pop_front();
          if (dv !== e.v || n_valid !== e.n || clipped !== e.clip) bad = 1'b1;
        end
        if (bad) begin $display("FAIL b2b_frame at cycle %0d nv %0d exp %0d", i, n_valid, e.n); errors++; end
      end
      if (acc && nacc < 8) begin
        sbq.push_back(model());
        acc_at[nacc] = i;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        cl[0] = {3'd1, 11'(50 + 200*nacc)};
        cl[1] = {3'd0, 11'(1530 - nacc)};
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (nacc != 3 || nout != 3) begin $display("FAIL b2b_count accepts %0d frames %0d exp 3/3", nacc, nout); errors++; end
    else begin
      checks++; if (acc_at[1] - acc_at[0] != 10 || acc_at[2] - acc_at[1] != 10) begin
        $display("FAIL b2b_spacing got %0d,%0d exp 10,10", acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]); errors++; end
    end
    checks++; if (sbq.size() != 0) begin $display("FAIL b2b_queue left %0d exp 0", sbq.size()); errors++; end
    sbq.delete();
  endtask

  task automatic test_reset_abort();
    int lat; exp_t e; logic bad;
    clear_cl();
    cl[0] = {3'd7, 11'd330};
    cl[3] = {3'd2, 11'd900};
    in_valid = 1'b1;
    sbq.push_back(model());
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    void'(sbq.pop_back());
    #1;
    checks++; if (dv !== '0 || n_valid !== 4'd0 || clipped !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL abort_outputs ov=%b ir=%b nv=%0d clip=%b vfat_or=%b exp all 0", out_valid, in_ready, n_valid, clipped, |dv); errors++; end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin $display("FAIL abort_held ir=%b ov=%b exp 0/0", in_ready, out_valid); errors++; end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin $display("FAIL abort_release ir=%b ov=%b exp 1/0", in_ready, out_valid); errors++; end
    clear_cl();
    cl[6] = {3'd0, 11'd1300};
    drive_frame(lat);
    checks++; bad = (lat != 8);
    if (sbq.size() == 0) bad = 1'b1;
    else begin
      e = sbq.pop_front();
      for (int i = 0; i < 24; i++) if (dv[i] !== e.v[i]) begin $display("FAIL abort_fresh vfat%0d got %h exp %h", i, dv[i], e.v[i]); bad = 1'b1; end
      if (n_valid !== e.n || clipped !== e.clip) bad = 1'b1;
    end
    if (bad) begin $display("FAIL abort_fresh lat %0d nv %0d exp 8/%0d", lat, n_valid, e.n); errors++; end
    release_frame();
  endtask

  initial begin
    test_reset();
    test_single();
    test_span();
    test_edge_clip();
    test_overlap();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
